// File: rtl/inverse_stride_pkg.sv
// Shared types and address helper for the inverse stride permutation block.
package inverse_stride_pkg;

  // Single-bank frame phase: collecting a frame, or emitting it.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Read order for the inverse stride: even output slots take the first
  // half of the frame, odd slots take the second half.
  function automatic int unsigned inv_stride_addr(input int unsigned idx,
                                                  input int unsigned n);
    return (idx >> 1) + (idx & 32'd1) * (n / 2);
  endfunction

endpackage

// File: rtl/inverse_stride_permutation_if.sv
// Valid/ready streaming channel carrying one sample per transfer.
interface inverse_stride_permutation_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 val;
  logic                 rdy;
  logic [BIT_WIDTH-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/inv_stride_addr_gen.sv
// Read counter for the drain side; maps the output position to the buffer
// slot holding that sample and flags the last position of a frame.
module inv_stride_addr_gen
  import inverse_stride_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  localparam int IDX_W = $clog2(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  output logic [IDX_W-1:0] rd_addr,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] rd_idx_d;

  assign last    = (rd_idx_q == IDX_LAST);
  assign rd_addr = IDX_W'(inv_stride_addr(32'(rd_idx_q), 32'(N_SAMPLES)));

  // Step on each send transfer, returning to 0 after the last position.
  always_comb begin
    rd_idx_d = rd_idx_q;
    if (advance) begin
      rd_idx_d = last ? '0 : rd_idx_q + IDX_W'(1);
    end
  end

  // Read counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx_q <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
    end
  end

endmodule

// File: rtl/inverse_stride_permutation.sv
// Streaming inverse Pease stride permutation: out[k] = in[k/2 + (k%2)*N/2].
// Optional feature macro INV_STRIDE_PINGPONG_EN: two buffer banks so one
// frame can fill while the previous one drains (1 sample/cycle sustained).
// Without it a single bank alternates between FILL and DRAIN.
module inverse_stride_permutation
  import inverse_stride_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  inverse_stride_permutation_if.slave   recv,
  inverse_stride_permutation_if.master  send
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

`ifdef INV_STRIDE_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  logic                 recv_fire;
  logic                 send_fire;
  logic                 wr_last;
  logic                 rd_last;
  logic [IDX_W-1:0]     rd_addr;
  logic [IDX_W-1:0]     wr_idx_q;
  logic [IDX_W-1:0]     wr_idx_d;
  logic [BIT_WIDTH-1:0] mem_q [NUM_BANKS*N_SAMPLES];
  logic [BIT_WIDTH-1:0] mem_d [NUM_BANKS*N_SAMPLES];

  assign recv_fire = recv.val && recv.rdy;
  assign send_fire = send.val && send.rdy;
  assign wr_last   = (wr_idx_q == IDX_LAST);

  inv_stride_addr_gen #(
    .N_SAMPLES (N_SAMPLES)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (send_fire),
    .rd_addr (rd_addr),
    .last    (rd_last)
  );

  // Write counter: natural arrival order, back to 0 after the last sample.
  always_comb begin
    wr_idx_d = wr_idx_q;
    if (recv_fire) begin
      wr_idx_d = wr_last ? '0 : wr_idx_q + IDX_W'(1);
    end
  end

  // Write counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_q <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
    end
  end

`ifdef INV_STRIDE_PINGPONG_EN
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic             wr_bank_q;
  logic             wr_bank_d;
  logic             rd_bank_q;
  logic             rd_bank_d;
  logic [IDX_W:0]   wr_mem_addr;
  logic [IDX_W:0]   rd_mem_addr;

  assign wr_mem_addr = {wr_bank_q, wr_idx_q};
  assign rd_mem_addr = {rd_bank_q, rd_addr};

  // Bank bookkeeping; a fill and a drain finishing together touch
  // different banks, so both updates simply apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (recv_fire && wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (send_fire && rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Bank flag and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Handshake outputs decode straight from the bank flags.
  always_comb begin
    recv.rdy = !full_q[wr_bank_q];
    send.val = full_q[rd_bank_q];
  end
`else
  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] wr_mem_addr;
  logic [IDX_W-1:0] rd_mem_addr;

  assign wr_mem_addr = wr_idx_q;
  assign rd_mem_addr = rd_addr;

  // Next phase: drain once the frame is complete, refill once it is sent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (recv_fire && wr_last) state_d = DRAIN;
      DRAIN:   if (send_fire && rd_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs decode straight from the phase.
  always_comb begin
    recv.rdy = (state_q == FILL);
    send.val = (state_q == DRAIN);
  end
`endif

  // Capture the accepted sample into its arrival slot.
  always_comb begin
    mem_d = mem_q;
    if (recv_fire) begin
      mem_d[wr_mem_addr] = recv.msg;
    end
  end

  // Sample storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output is zero whenever no sample is being offered.
  always_comb begin
    send.msg = send.val ? mem_q[rd_mem_addr] : '0;
  end

endmodule

// File: tb/tb_inverse_stride_permutation.sv
// Directed bench for inverse_stride_permutation (N=8 and N=2 instances).
// Ping-pong checks are compiled in when INV_STRIDE_PINGPONG_EN is defined.
module tb_inverse_stride_permutation;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  inverse_stride_permutation_if #(.BIT_WIDTH(32)) r8 ();
  inverse_stride_permutation_if #(.BIT_WIDTH(32)) s8 ();
  inverse_stride_permutation_if #(.BIT_WIDTH(32)) r2 ();
  inverse_stride_permutation_if #(.BIT_WIDTH(32)) s2 ();

  inverse_stride_permutation #(.N_SAMPLES(8), .BIT_WIDTH(32)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .recv    (r8),
    .send    (s8)
  );

  inverse_stride_permutation #(.N_SAMPLES(2), .BIT_WIDTH(32)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .recv    (r2),
    .send    (s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived output order for N=8: position k reads input perm8[k].
  int perm8 [8] = '{0, 4, 1, 5, 2, 6, 3, 7};
  logic [31:0] rnd_in [160];
  logic [31:0] pp_in [24];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_budget(input string tag, input int b);
    total++;
    assert (b > 0) else begin
      bad++;
      $error("FAIL %s observed=timeout expected=handshake", tag);
    end
  endtask

  task automatic push8(input logic [31:0] d);
    int b = 200;
    r8.val = 1'b1;
    r8.msg = d;
    while (!r8.rdy && b > 0) begin @(posedge clk); #1; b--; end
    @(posedge clk); #1;
    r8.val = 1'b0;
    r8.msg = '0;
    chk_budget("push8_timeout", b);
  endtask

  task automatic pop8(output logic [31:0] d);
    int b = 200;
    s8.rdy = 1'b1;
    while (!s8.val && b > 0) begin @(posedge clk); #1; b--; end
    d = s8.msg;
    @(posedge clk); #1;
    s8.rdy = 1'b0;
    chk_budget("pop8_timeout", b);
  endtask

  task automatic push2(input logic [31:0] d);
    int b = 200;
    r2.val = 1'b1;
    r2.msg = d;
    while (!r2.rdy && b > 0) begin @(posedge clk); #1; b--; end
    @(posedge clk); #1;
    r2.val = 1'b0;
    r2.msg = '0;
    chk_budget("push2_timeout", b);
  endtask

  task automatic pop2(output logic [31:0] d);
    int b = 200;
    s2.rdy = 1'b1;
    while (!s2.val && b > 0) begin @(posedge clk); #1; b--; end
    d = s2.msg;
    @(posedge clk); #1;
    s2.rdy = 1'b0;
    chk_budget("pop2_timeout", b);
  endtask

  initial begin
    logic [31:0] d;
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    r8.val = 1'b0; r8.msg = '0; s8.rdy = 1'b0;
    r2.val = 1'b0; r2.msg = '0; s2.rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    chk("rst_recv_rdy", 32'(r8.rdy), 32'd1);
    chk("rst_send_val", 32'(s8.val), 32'd0);
    chk("rst_send_msg", s8.msg, 32'd0);
    chk("rst2_recv_rdy", 32'(r2.rdy), 32'd1);

    // Basic frame 0..7, one-cycle latency to send_val.
    for (int i = 0; i < 8; i++) begin
      push8(32'(i));
      if (i == 6) chk("basic_val_early", 32'(s8.val), 32'd0);
    end
    chk("basic_val_latency", 32'(s8.val), 32'd1);
    chk("basic_first_msg", s8.msg, 32'd0);
    chk("basic_recv_rdy_low", 32'(r8.rdy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      pop8(d);
      chk("basic_out", d, 32'(perm8[k]));
    end
    chk("basic_end_val", 32'(s8.val), 32'd0);
    chk("basic_end_msg", s8.msg, 32'd0);
    chk("basic_end_rdy", 32'(r8.rdy), 32'd1);

    // Minimum size N=2.
    push2(32'hA);
    push2(32'hB);
    chk("n2_val", 32'(s2.val), 32'd1);
    pop2(d);
    chk("n2_out0", d, 32'hA);
    pop2(d);
    chk("n2_out1", d, 32'hB);
    chk("n2_recv_rdy", 32'(r2.rdy), 32'd1);
    chk("n2_send_val", 32'(s2.val), 32'd0);

    // Backpressure: hold send_rdy low for 5 cycles.
    for (int i = 0; i < 8; i++) push8(32'(i));
    for (int c = 0; c < 5; c++) begin
      chk("bp_val", 32'(s8.val), 32'd1);
      chk("bp_msg", s8.msg, 32'd0);
      chk("bp_rd_idx", 32'(dut8.u_addr_gen.rd_idx_q), 32'd0);
`ifndef INV_STRIDE_PINGPONG_EN
      chk("bp_recv_rdy", 32'(r8.rdy), 32'd0);
`endif
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) begin
      pop8(d);
      chk("bp_out", d, 32'(perm8[k]));
    end

    // Random bubbles on both sides, 20 frames of random data.
    fork
      begin
        for (int i = 0; i < 160; i++) begin
          while ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          rnd_in[i] = $urandom;
          push8(rnd_in[i]);
        end
      end
      begin
        logic [31:0] q;
        for (int k = 0; k < 160; k++) begin
          while ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          pop8(q);
          chk("rand_out", q, rnd_in[(k / 8) * 8 + perm8[k % 8]]);
        end
      end
    join

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) push8(32'(100 + i));
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("mid_rst_val", 32'(s8.val), 32'd0);
    chk("mid_rst_rdy", 32'(r8.rdy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) chk("mid_val_early", 32'(s8.val), 32'd0);
      push8(32'(i));
    end
    chk("mid_val", 32'(s8.val), 32'd1);
    for (int k = 0; k < 8; k++) begin
      pop8(d);
      chk("mid_out", d, 32'(perm8[k]));
    end

`ifdef INV_STRIDE_PINGPONG_EN
    // Three back-to-back frames, continuous output once the first completes.
    for (int i = 0; i < 24; i++) pp_in[i] = 32'h5000 + 32'(i * 3);
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          chk("pp_recv_rdy", 32'(r8.rdy), 32'd1);
          push8(pp_in[i]);
        end
      end
      begin
        logic [31:0] q;
        for (int k = 0; k < 24; k++) begin
          if (k > 0) chk("pp_send_val", 32'(s8.val), 32'd1);
          pop8(q);
          chk("pp_out", q, pp_in[(k / 8) * 8 + perm8[k % 8]]);
        end
      end
    join
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
